// File: rtl/cpu_int_pkg.sv
// cpu_int_pkg: shared types and constants for the CPU interrupt path.
//   int_kind_t  - interrupt kind encoding presented on ih_kind
//   arb_state_t - interrupt_arbiter FSM states
//   VEC_*       - vector addresses, shared with interrupt_handler
package cpu_int_pkg;

    typedef enum logic [1:0] {
        INT_RESET = 2'd0,
        INT_NMI   = 2'd1,
        INT_IRQ   = 2'd2,
        INT_BRK   = 2'd3
    } int_kind_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic [15:0] VEC_NMI     = 16'hFFFA;
    localparam logic [15:0] VEC_RESET   = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_BRK = 16'hFFFE;

endpackage

// File: rtl/int_edge_detect.sv
// int_edge_detect: optional synchroniser followed by rise/fall pulse detection.
// Ports:
//   clk, rst  - clock, asynchronous active-low reset
//   sig       - raw input (asynchronous when DEPTH > 0)
//   level     - synchronised level (sig itself when DEPTH == 0)
//   rise/fall - one-cycle pulses on a level change relative to the previous cycle
// RESET_VAL seeds both the synchroniser and the previous-level flop, so a
// level already at RESET_VAL when reset releases produces no edge.
module int_edge_detect
    import cpu_int_pkg::*;
#(
    parameter int unsigned DEPTH     = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic level,
    output logic rise,
    output logic fall
);

    logic prev_q;

    generate
        if (DEPTH == 0) begin : g_direct
            assign level = sig;
        end else begin : g_sync
            logic [DEPTH-1:0] sync_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) sync_q <= {DEPTH{RESET_VAL}};
                else      sync_q <= (sync_q << 1) | DEPTH'(sig);
            end
            assign level = sync_q[DEPTH-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) prev_q <= RESET_VAL;
        else      prev_q <= level;
    end

    assign rise = level & ~prev_q;
    assign fall = ~level & prev_q;

endmodule

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: latches and prioritises RESET/NMI/BRK/IRQ requests and
// issues one start/kind request at a time to interrupt_handler, holding the
// core until the handler reports done.
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   ppu_status[7]   - vblank; ANDed with ppu_nmi_en to form the NMI line
//   irq_n           - asynchronous active-low IRQ level
//   soft_reset      - active-low reset request, must stay low RESET_HOLD cycles
//   break_flag      - BRK in decode (valid with instr_boundary)
//   status_i        - CPU I flag, masks IRQ
//   instr_boundary  - core may be interrupted this cycle
//   ih_start/ih_kind/ih_done - handshake with interrupt_handler
//   cpu_hold        - core stall while a sequence is in flight
//   nmi_pending     - NMI latched but not yet issued
// Build option: define INT_ARB_IRQ_LATCH_EN to latch a falling edge of the
// synchronised irq_n so short IRQ pulses are still serviced.
module interrupt_arbiter
    import cpu_int_pkg::*;
#(
    parameter int unsigned RESET_HOLD = 2,
    parameter int unsigned IRQ_SYNC   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ppu_status,
    input  logic       ppu_nmi_en,
    input  logic       irq_n,
    input  logic       soft_reset,
    input  logic       break_flag,
    input  logic       status_i,
    input  logic       instr_boundary,
    output logic       ih_start,
    output logic [1:0] ih_kind,
    input  logic       ih_done,
    output logic       cpu_hold,
    output logic       nmi_pending
);

    localparam logic [3:0] HOLD_CNT = 4'(RESET_HOLD);

    arb_state_t state_q, state_d;
    int_kind_t  kind_q, kind_d;
    logic       reset_pend_q, reset_pend_d;
    logic       nmi_pend_q, nmi_pend_d;
    logic [3:0] srst_cnt_q, srst_cnt_d;
    logic       srst_hit;

    // Source conditioning
    logic nmi_line, nmi_level, nmi_rise, nmi_fall;
    logic irq_level, irq_rise, irq_fall, irq_act, irq_req;

    assign nmi_line = ppu_status[7] & ppu_nmi_en;

    // nmi_prev resets high so an already-set vblank does not fire at release.
    int_edge_detect #(
        .DEPTH    (0),
        .RESET_VAL(1'b1)
    ) u_nmi_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  (nmi_line),
        .level(nmi_level),
        .rise (nmi_rise),
        .fall (nmi_fall)
    );

    int_edge_detect #(
        .DEPTH    (IRQ_SYNC),
        .RESET_VAL(1'b1)
    ) u_irq_sync (
        .clk  (clk),
        .rst  (rst),
        .sig  (irq_n),
        .level(irq_level),
        .rise (irq_rise),
        .fall (irq_fall)
    );

    assign irq_act = ~irq_level;

    logic unused_sigs;
    assign unused_sigs = ^{ppu_status[6:0], nmi_level, nmi_fall, irq_rise, irq_fall};

    // Soft reset: counter saturates at HOLD_CNT so the request fires once per
    // low period and re-arms only when soft_reset returns high.
    always_comb begin
        srst_cnt_d = srst_cnt_q;
        srst_hit   = 1'b0;
        if (soft_reset) begin
            srst_cnt_d = '0;
        end else if (srst_cnt_q != HOLD_CNT) begin
            srst_cnt_d = srst_cnt_q + 4'd1;
            srst_hit   = (srst_cnt_d == HOLD_CNT);
        end
    end

    // Arbitration
    logic      grant, accept;
    int_kind_t grant_kind;

    always_comb begin
        grant      = 1'b1;
        grant_kind = INT_RESET;
        if (reset_pend_q)                        grant_kind = INT_RESET;
        else if (instr_boundary && nmi_pend_q)   grant_kind = INT_NMI;
        else if (instr_boundary && break_flag)   grant_kind = INT_BRK;
        else if (instr_boundary && irq_req)      grant_kind = INT_IRQ;
        else                                     grant      = 1'b0;
    end

    assign accept = (state_q == IDLE) && grant;

    // A fresh request in the same cycle as an issue of that kind stays pending.
    assign reset_pend_d = srst_hit | (reset_pend_q & ~(accept && grant_kind == INT_RESET));
    assign nmi_pend_d   = nmi_rise | (nmi_pend_q & ~(accept && grant_kind == INT_NMI));

`ifdef INT_ARB_IRQ_LATCH_EN
    logic irq_pend_q, irq_pend_d;

    assign irq_pend_d = irq_fall | (irq_pend_q & ~(accept && grant_kind == INT_IRQ));
    assign irq_req    = (irq_pend_q | irq_act) & ~status_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq_pend_q <= 1'b0;
        else      irq_pend_q <= irq_pend_d;
    end
`else
    assign irq_req = irq_act & ~status_i;
`endif

    // FSM
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = ISSUE;
                    kind_d  = grant_kind;
                end
            end
            ISSUE:   state_d = WAIT;
            WAIT:    if (ih_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            kind_q       <= INT_RESET;
            reset_pend_q <= 1'b1;
            nmi_pend_q   <= 1'b0;
            srst_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            reset_pend_q <= reset_pend_d;
            nmi_pend_q   <= nmi_pend_d;
            srst_cnt_q   <= srst_cnt_d;
        end
    end

    assign ih_start    = (state_q == ISSUE);
    assign ih_kind     = kind_q;
    assign cpu_hold    = (state_q == ISSUE) || (state_q == WAIT);
    assign nmi_pending = nmi_pend_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Directed bench for interrupt_arbiter. Stimulus pushes the expected issue
// (kind and cycle) into a queue; a negedge monitor pops and compares on every
// ih_start, and flags any issue nobody expected.
module tb_interrupt_arbiter;

    localparam int IRQ_SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ppu_status;
    logic       ppu_nmi_en;
    logic       irq_n;
    logic       soft_reset;
    logic       break_flag;
    logic       status_i;
    logic       instr_boundary;
    logic       ih_start;
    logic [1:0] ih_kind;
    logic       ih_done;
    logic       cpu_hold;
    logic       nmi_pending;

    interrupt_arbiter #(
        .RESET_HOLD(2),
        .IRQ_SYNC  (IRQ_SYNC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ppu_status    (ppu_status),
        .ppu_nmi_en    (ppu_nmi_en),
        .irq_n         (irq_n),
        .soft_reset    (soft_reset),
        .break_flag    (break_flag),
        .status_i      (status_i),
        .instr_boundary(instr_boundary),
        .ih_start      (ih_start),
        .ih_kind       (ih_kind),
        .ih_done       (ih_done),
        .cpu_hold      (cpu_hold),
        .nmi_pending   (nmi_pending)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] kind;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [1:0] last_kind = 2'd0;
    int         vectors = 0;
    int         miscompares = 0;

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            if (ih_start) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_issue: got kind %0d at cycle %0d, required none",
                             ih_kind, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (ih_kind !== mon_e.kind || cyc != mon_e.cyc) begin
                        miscompares++;
                        $display("FAIL issue: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                                 ih_kind, cyc, mon_e.kind, mon_e.cyc);
                    end
                end
                last_kind = ih_kind;
            end else if (cpu_hold) begin
                vectors++;
                if (ih_kind !== last_kind) begin
                    miscompares++;
                    $display("FAIL kind_stable: got %0d required %0d at cycle %0d",
                             ih_kind, last_kind, cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h at cycle %0d", name, got, want, cyc);
        end
    endtask

    task automatic expect_issue(input logic [1:0] kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for the hold, let the handler run 'delay' cycles, pulse done.
    task automatic serve(input int delay);
        int n = 0;
        while (!cpu_hold && n < 50) begin
            tick();
            n++;
        end
        check("hold_seen", cpu_hold, 1'b1);
        repeat (delay) tick();
        check("hold_before_done", cpu_hold, 1'b1);
        ih_done = 1'b1;
        tick();
        ih_done = 1'b0;
        check("hold_after_done", cpu_hold, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst            = 1'b0;
        ppu_status     = 8'h00;
        ppu_nmi_en     = 1'b0;
        irq_n          = 1'b1;
        soft_reset     = 1'b1;
        break_flag     = 1'b0;
        status_i       = 1'b0;
        instr_boundary = 1'b1;
        ih_done        = 1'b0;
        #1;
        check("rst_ih_start", ih_start, 1'b0);
        check("rst_ih_kind", ih_kind, 2'd0);
        check("rst_cpu_hold", cpu_hold, 1'b0);
        check("rst_nmi_pending", nmi_pending, 1'b0);

        // Power-on RESET issued the first cycle after release
        repeat (3) tick();
        rst = 1'b1;
        expect_issue(2'd0, cyc + 1);
        serve(5);

        // Soft reset: 1-cycle glitch ignored, long low gives exactly one RESET
        soft_reset = 1'b0;
        tick();
        soft_reset = 1'b1;
        repeat (5) tick();
        soft_reset = 1'b0;
        expect_issue(2'd0, cyc + 3);
        serve(3);
        repeat (8) tick();
        soft_reset = 1'b1;
        tick();

        // BRK, with NMI arriving during its WAIT
        break_flag = 1'b1;
        expect_issue(2'd3, cyc + 1);
        tick();
        tick();
        break_flag = 1'b0;
        ppu_nmi_en = 1'b1;
        ppu_status = 8'h80;
        tick();
        check("nmi_pending_in_wait", nmi_pending, 1'b1);
        check("hold_in_brk_wait", cpu_hold, 1'b1);
        ih_done = 1'b1;
        expect_issue(2'd1, cyc + 2);
        tick();
        ih_done = 1'b0;
        check("hold_drop_brk", cpu_hold, 1'b0);
        check("nmi_still_pending", nmi_pending, 1'b1);
        serve(2);
        check("nmi_cleared", nmi_pending, 1'b0);
        ppu_status = 8'h00;
        ppu_nmi_en = 1'b0;
        repeat (3) tick();

        // Enable NMI while vblank already high; long level gives one NMI
        ppu_status = 8'h80;
        repeat (3) tick();
        ppu_nmi_en = 1'b1;
        expect_issue(2'd1, cyc + 2);
        serve(2);
        repeat (20) tick();
        check("nmi_level_once", nmi_pending, 1'b0);
        ppu_status = 8'h00;
        ppu_nmi_en = 1'b0;
        tick();

        // IRQ masked by I flag, then issued when cleared
        status_i = 1'b1;
        irq_n    = 1'b0;
        repeat (10) tick();
        check("irq_masked_no_hold", cpu_hold, 1'b0);
        status_i = 1'b0;
        expect_issue(2'd2, cyc + 1);
        tick();
        irq_n = 1'b1;
        serve(5);
        repeat (3) tick();

        // irq_n low to ih_start latency
        irq_n = 1'b0;
        expect_issue(2'd2, cyc + IRQ_SYNC + 1);
        repeat (IRQ_SYNC + 1) tick();
        irq_n = 1'b1;
        serve(3);
        repeat (3) tick();

        // Short IRQ pulse while masked
        status_i = 1'b1;
        irq_n    = 1'b0;
        tick();
        irq_n = 1'b1;
        repeat (5) tick();
        status_i = 1'b0;
`ifdef INT_ARB_IRQ_LATCH_EN
        expect_issue(2'd2, cyc + 1);
        serve(2);
`else
        repeat (6) tick();
        check("irq_pulse_dropped", cpu_hold, 1'b0);
`endif
        repeat (3) tick();

        // NMI, BRK and IRQ together: order NMI, BRK, IRQ
        instr_boundary = 1'b0;
        ppu_status     = 8'h80;
        ppu_nmi_en     = 1'b1;
        break_flag     = 1'b1;
        irq_n          = 1'b0;
        repeat (3) tick();
        instr_boundary = 1'b1;
        expect_issue(2'd1, cyc + 1);
        serve(2);
        expect_issue(2'd3, cyc + 1);
        tick();
        tick();
        break_flag = 1'b0;
        serve(2);
        expect_issue(2'd2, cyc + 1);
        tick();
        irq_n = 1'b1;
        tick();
        tick();
        check("irq_kind_in_wait", ih_kind, 2'd2);
        check("irq_hold_in_wait", cpu_hold, 1'b1);

        // Asynchronous reset mid-WAIT
        rst = 1'b0;
        #1;
        check("async_ih_start", ih_start, 1'b0);
        check("async_ih_kind", ih_kind, 2'd0);
        check("async_cpu_hold", cpu_hold, 1'b0);
        check("async_nmi_pending", nmi_pending, 1'b0);
        tick();
        rst = 1'b1;
        expect_issue(2'd0, cyc + 1);
        serve(2);
        repeat (10) tick();
        check("no_nmi_after_reset", nmi_pending, 1'b0);
        check("no_issue_after_reset", cpu_hold, 1'b0);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_issue: got %0d outstanding required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
